// File: rtl/ram_unit_pkg.sv
// Shared types and helpers for the RAM unit.
// The operation code is latched when a request is captured.
package ram_unit_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        OP_READ,
        OP_WRITE,
        OP_BAD
    } op_e;

    // Exactly one pin selects an operation.
    // Both pins together is an illegal request.
    function automatic op_e decode_op(input logic rd, input logic wr);
        op_e op;
        op = OP_BAD;
        unique case (1'b1)
            (rd && !wr): op = OP_READ;
            (wr && !rd): op = OP_WRITE;
            default:     op = OP_BAD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/ram_array.sv
// Single-port word-wide storage with a synchronous write.
// The read is combinational from the shared index.
module ram_array #(
    parameter int word_width = 32,
    parameter int addr_width = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [addr_width-1:0] index,
    input  logic [word_width-1:0] wdata,
    output logic [word_width-1:0] rdata
);

    logic [word_width-1:0] mem [0:(1<<addr_width)-1];

    // The write port. Reset does not clear the contents.
    always_ff @(posedge clk) begin
        if (we) mem[index] <= wdata;
    end

    assign rdata = mem[index];

endmodule

// File: rtl/ram_defines.sv
// Bit positions shared between the RAM unit and the motherboard FSM.
// Include this file. It defines macros only.
`ifndef RAM_DEFINES_SV
`define RAM_DEFINES_SV

`define RAM_READ_PIN  0
`define RAM_WRITE_PIN 1

`define RAM_ACK  0
`define RAM_BUSY 1
`define RAM_ERR  2

`endif

// File: rtl/ram_unit.sv
// RAM unit with a fixed access latency and a four-phase handshake.
// A request is captured in IDLE and completes after `latency` edges.
`include "ram_defines.sv"

module ram_unit
    import ram_unit_pkg::*;
#(
    parameter int word_width = 32,
    parameter int addr_width = 10,
    parameter int latency    = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [word_width-1:0] ram_ctrl,
    input  logic [word_width-1:0] addr,
    input  logic [word_width-1:0] data_out,
    output logic [word_width-1:0] ram_stat,
    output logic [word_width-1:0] data_in
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    state_e                state;
    logic [CNT_W-1:0]      cnt;
    op_e                   op;
    logic [word_width-1:0] addr_q;
    logic [word_width-1:0] wdata_q;
    logic                  err;

    logic                  rd;
    logic                  wr;
    logic                  bad_addr;
    logic                  fault;
    logic                  finish;
    logic                  we;
    logic [addr_width-1:0] index;
    logic [word_width-1:0] rdata;
    logic                  unused_ctrl;

    assign rd = ram_ctrl[`RAM_READ_PIN];
    assign wr = ram_ctrl[`RAM_WRITE_PIN];
    assign unused_ctrl = ^ram_ctrl;

    // Misaligned or above the top word.
    assign bad_addr = (addr_q[1:0] != 2'b00) ||
                      ((addr_q >> (addr_width + 2)) != '0);
    assign fault    = bad_addr || (op == OP_BAD);
    assign index    = addr_q[addr_width+1:2];

    // The op lands on the edge that enters DONE.
    // A reset on that edge wins and the write is dropped.
    assign finish = (state == BUSY) && (cnt == '0);
    assign we     = finish && rst_n && (op == OP_WRITE) && !fault;

    ram_array #(
        .word_width(word_width),
        .addr_width(addr_width)
    ) u_array (
        .clk  (clk),
        .we   (we),
        .index(index),
        .wdata(wdata_q),
        .rdata(rdata)
    );

    // Handshake FSM: capture, count down, complete, wait for release.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            err     <= 1'b0;
            data_in <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (rd || wr) begin
                        op      <= decode_op(rd, wr);
                        addr_q  <= addr;
                        wdata_q <= data_out;
                        cnt     <= CNT_W'(latency - 1);
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        state <= DONE;
                        err   <= fault;
                        if (op == OP_READ) begin
                            data_in <= fault ? '0 : rdata;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (!rd && !wr) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The status word is decoded from registered state only.
    always_comb begin
        ram_stat            = '0;
        ram_stat[`RAM_ACK]  = (state == DONE);
        ram_stat[`RAM_BUSY] = (state == BUSY);
        ram_stat[`RAM_ERR]  = err;
    end

endmodule

// File: tb/tb_ram_unit.sv
// Randomized self-checking bench for ram_unit.
// Two instances, latency 3 and latency 1, see the same stimulus.
module tb_ram_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] ram_ctrl;
    logic [31:0] addr;
    logic [31:0] data_out;
    logic [31:0] stat3, din3;
    logic [31:0] stat1, din1;

    int n_tests = 0;
    int n_fail  = 0;

    // The model covers words 0..63. Good requests stay in that range.
    logic [31:0] mem_m [64];
    logic        m_err;
    logic [31:0] m_din;

    always #5 clk = ~clk;

    ram_unit u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ram_ctrl(ram_ctrl),
        .addr    (addr),
        .data_out(data_out),
        .ram_stat(stat3),
        .data_in (din3)
    );

    ram_unit #(.latency(1)) u_dut1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .ram_ctrl(ram_ctrl),
        .addr    (addr),
        .data_out(data_out),
        .ram_stat(stat1),
        .data_in (din1)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] st(input logic e, input logic b,
                                       input logic a);
        return {29'd0, e, b, a};
    endfunction

    // One full handshake. Ops complete at capture+3 on u_dut and at
    // capture+1 on u_dut1. With early set, the pins drop one cycle
    // after capture. Otherwise they are held for hold cycles after ACK.
    task automatic xact(input logic [1:0] pins, input logic [31:0] a,
                        input logic [31:0] d, input int hold,
                        input bit early);
        bit          rd, wr, bad;
        logic        pe, ne;
        logic [31:0] pd, nd;
        int          last;
        logic        b3, a3, b1, a1;
        rd  = pins[0];
        wr  = pins[1];
        bad = (a[1:0] != 2'b00) || ((a >> 12) != 0) || (rd && wr);
        pe  = m_err;
        pd  = m_din;
        ne  = bad;
        nd  = pd;
        if (rd && !wr) nd = bad ? 32'd0 : mem_m[a[7:2]];
        ram_ctrl = ($urandom() & 32'hFFFF_FFFC) | {30'd0, pins};
        addr     = a;
        data_out = d;
        last     = early ? 4 : 3 + hold;
        for (int k = 0; k <= last; k++) begin
            @(negedge clk);
            b3 = (k < 3);
            a3 = (k >= 3) && !(early && k >= 4);
            b1 = (k == 0);
            a1 = (k >= 1) && !(early && k >= 2);
            chk("stat_lat3", stat3, st(k >= 3 ? ne : pe, b3, a3));
            chk("din_lat3", din3, (k >= 3) ? nd : pd);
            chk("stat_lat1", stat1, st(k >= 1 ? ne : pe, b1, a1));
            chk("din_lat1", din1, (k >= 1) ? nd : pd);
            if (k == 0) begin
                addr     = $urandom();
                data_out = $urandom();
                ram_ctrl = ($urandom() & 32'hFFFF_FFFC) | {30'd0, pins};
                if (early) ram_ctrl[1:0] = 2'b00;
            end
        end
        if (!early) begin
            ram_ctrl[1:0] = 2'b00;
            @(negedge clk);
            chk("idle_lat3", stat3, st(ne, 1'b0, 1'b0));
            chk("idle_lat1", stat1, st(ne, 1'b0, 1'b0));
        end
        m_err = ne;
        m_din = nd;
        if (wr && !rd && !bad) mem_m[a[7:2]] = d;
    endtask

    // Pins low in IDLE must leave everything unchanged.
    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            ram_ctrl = $urandom() & 32'hFFFF_FFFC;
            addr     = $urandom();
            data_out = $urandom();
            @(negedge clk);
            chk("quiet_lat3", stat3, st(m_err, 1'b0, 1'b0));
            chk("quiet_din3", din3, m_din);
            chk("quiet_lat1", stat1, st(m_err, 1'b0, 1'b0));
        end
    endtask

    // Reset lands one cycle into BUSY of a write, which must be lost.
    task automatic reset_mid_write(input logic [31:0] a,
                                   input logic [31:0] d);
        ram_ctrl = 32'h2;
        addr     = a;
        data_out = d;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_stat3", stat3, 32'd0);
        chk("rst_din3", din3, 32'd0);
        chk("rst_stat1", stat1, 32'd0);
        chk("rst_din1", din1, 32'd0);
        rst_n    = 1'b1;
        ram_ctrl = 32'd0;
        m_err    = 1'b0;
        m_din    = 32'd0;
        @(negedge clk);
    endtask

    function automatic logic [31:0] good_addr();
        return {24'd0, 6'($urandom_range(0, 63)), 2'b00};
    endfunction

    function automatic logic [31:0] bad_addr();
        logic [31:0] a;
        a = good_addr();
        if ($urandom_range(0, 1) == 0)
            a[1:0] = 2'($urandom_range(1, 3));
        else
            a = a | (32'd1 << $urandom_range(12, 31));
        return a;
    endfunction

    initial begin
        logic [1:0]  pins;
        logic [31:0] a;
        int          kind;

        rst_n    = 1'b0;
        ram_ctrl = 32'd0;
        addr     = 32'd0;
        data_out = 32'd0;
        m_err    = 1'b0;
        m_din    = 32'd0;
        repeat (3) @(negedge clk);
        chk("reset_stat3", stat3, 32'd0);
        chk("reset_din3", din3, 32'd0);
        chk("reset_stat1", stat1, 32'd0);
        chk("reset_din1", din1, 32'd0);
        rst_n = 1'b1;
        idle_cycles(3);

        for (int i = 0; i < 64; i++)
            xact(2'b10, {24'd0, 6'(i), 2'b00}, $urandom(), 0, 1'b0);

        xact(2'b10, 32'h10, 32'hDEADBEEF, 0, 1'b0);
        xact(2'b01, 32'h10, 32'd0, 0, 1'b0);
        xact(2'b10, 32'h14, 32'h1234_5678, 5, 1'b0);
        xact(2'b01, 32'h14, 32'd0, 0, 1'b0);
        xact(2'b01, 32'h2, 32'd0, 0, 1'b0);
        xact(2'b01, 32'h1000, 32'd0, 1, 1'b0);
        xact(2'b10, 32'h1010, 32'hBAD0_BAD0, 0, 1'b0);
        xact(2'b01, 32'h10, 32'd0, 0, 1'b0);
        xact(2'b10, 32'h20, 32'hCAFE_F00D, 0, 1'b0);
        xact(2'b01, 32'h20, 32'd0, 0, 1'b0);
        xact(2'b11, 32'h20, 32'h0, 0, 1'b0);
        xact(2'b01, 32'h20, 32'd0, 0, 1'b1);
        idle_cycles(2);

        reset_mid_write(32'h20, 32'h5555_AAAA);
        xact(2'b01, 32'h20, 32'd0, 0, 1'b0);

        for (int i = 0; i < 200; i++) begin
            kind = $urandom_range(0, 9);
            a    = good_addr();
            pins = 2'b01;
            if (kind < 4) pins = 2'b10;
            else if (kind == 8) a = bad_addr();
            else if (kind == 9) pins = 2'b11;
            if (kind == 7) pins = 2'b10;
            if (kind == 7) a = bad_addr();
            xact(pins, a, $urandom(), $urandom_range(0, 3),
                 $urandom_range(0, 5) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
